timer_top_core: RTL and testbench
=================================

// Module: timer_top_core
// PURPOSE
//  Microwave-style MM:SS countdown timer. Scans a 4-column x 5-row key matrix, debounces keys and edits a 4-digit BCD time.
//  Counts down at 1 Hz while enabled by i_start_sw. Drives a multiplexed 4-digit 7-seg display, status LEDs and a buzzer.
//  FPGA top level. The keypad is external; benches use a behavioural matrix model.
// PARAMETERS
//  CLK_HZ      10_000_000  clock frequency; 1 s tick = CLK_HZ cycles
//  SCAN_CYC    10_000      clocks per column scan slot; also clocks per display digit slot
//  DEB_FRAMES  5           full 4-column frames a key state must be stable before it is accepted
//  DONE_SEC    3           seconds spent in DONE before auto-return to IDLE
//  BUZZ_DIV    5_000       half-period of buzzer square wave in clocks (1 kHz @10 MHz)
// PORTS
//  i_clk       in   1  system clock
//  i_rst       in   1  synchronous reset, active-high
//  i_start_sw  in   1  run-enable switch (level); 2-FF synchronised internally
//  i_key_in    in   5  matrix rows; one-hot active-high for the pressed key in the driven column
//  o_key_out   out  4  matrix column drive; one-hot active-high, rotates every SCAN_CYC
//  o_buzzer    out  1  buzzer drive
//  o_led       out  4  [0]RUN [1]PAUSE [2]DONE [3]IDLE
//  o_seg_d     out  8  segments {dp,g,f,e,d,c,b,a}, active-high
//  o_seg_com   out  4  digit enable, active-low; [3]=min tens .. [0]=sec ones
// BEHAVIOUR
//  Reset (synchronous, active-high): all regs cleared; time 00:00; state IDLE; o_key_out=4'b0001; o_buzzer=0;
//   o_led=4'b1000; o_seg_com=4'b1111; o_seg_d=8'h00. All outputs are registered.
//  Key code: row r (0..4), column c (0..3) -> code = 4r+c+1 (1..20); 0 = none.
//   A press is accepted once, when a nonzero code has been stable for DEB_FRAMES frames. The next press is
//   accepted only after no key has been seen for DEB_FRAMES frames. Two rows active in one column: lowest row wins.
//  Key functions, accepted only in IDLE or PAUSE (PAUSE edits stay paused):
//   1..9 = digits 1..9; 10 = digit 0. Shift-in: {m1,m0,s1,s0} <= {m0,s1,s0,d}. s1 may exceed 5; 07:89 is legal.
//   12 = +1 min: minutes saturate at 99.
//   13 = +10 s: if s1>=5 then s1=0 and +1 min (min saturates at 99), else s1+1.
//   14 = clear: time 00:00, state IDLE.
//   11, 15..20 = ignored.
//  Any accepted key in DONE -> IDLE; the time is not edited.
//  FSM:
//   IDLE  -> RUN   on synchronised i_start_sw rising edge with time != 0; edge ignored when time = 0.
//   RUN   -> PAUSE when i_start_sw = 0.
//   PAUSE -> RUN   when i_start_sw = 1.
//   RUN   -> DONE  in the same cycle the decrement reaches 00:00.
//   DONE  -> IDLE  after DONE_SEC s, any accepted key, or i_start_sw = 0.
//  1 s prescaler: cleared on IDLE->RUN; held in PAUSE; a tick every CLK_HZ cycles in RUN.
//   Tick decrements the time:
//    - s0>0: s0-1.
//    - else s1>0: s1-1, s0=9.
//    - else: min-1, seconds=59.
//   First decrement occurs CLK_HZ cycles after entering RUN.
//  Display: each digit slot lasts SCAN_CYC; order 3,2,1,0. Standard hex-free 0-9 patterns; leading zeros shown.
//   dp lit on digit 2 (MM.SS).
//  Buzzer: square wave (period 2*BUZZ_DIV) for the whole of DONE; 0 otherwise.
//  Reset mid-count returns to IDLE 00:00 within one clock.
// CONFIGURATION
//  KEY_CLICK_EN defined: each accepted key press sounds the buzzer square wave for 50 ms (CLK_HZ/20 cycles).
//   This overlays DONE.
//  KEY_CLICK_EN undefined: buzzer sounds only in DONE.
// TESTING (behavioural keypad model returns the row for the driven column; 33 ms presses/gaps at CLK_HZ=10 MHz)
//  Keys 12,12 -> display 02:00; then keys 13,13 -> 02:20.
//  Key 14 -> 00:00; then keys 7,8,9 -> 07:89.
//  i_start_sw 1->0->1 with 07:89 -> RUN (o_led=0001); after CLK_HZ cycles shows 07:88.
//   i_start_sw=0 -> PAUSE (o_led=0010); value frozen.
//  Load 00:01, start -> after 1 s display 00:00, DONE; o_buzzer toggles every BUZZ_DIV.
//   IDLE after DONE_SEC s.
//  Start edge with 00:00 -> stays IDLE. A key held 200 ms is accepted once.
//   A 10 ms glitch (< DEB_FRAMES frames) is ignored.
//  Reset asserted in RUN -> next clock o_led=1000, time 00:00, o_buzzer=0.

Source files
------------

// File: rtl/timer_top_core.sv
// rtl/timer_top_core.sv - MM:SS countdown timer: keypad scan/debounce, BCD time edit, 7-seg mux, buzzer.
// Optional KEY_CLICK_EN: every accepted key also sounds the buzzer for CLK_HZ/20 cycles.
module timer_top_core #(
  parameter int CLK_HZ     = 10_000_000,
  parameter int SCAN_CYC   = 10_000,
  parameter int DEB_FRAMES = 5,
  parameter int DONE_SEC   = 3,
  parameter int BUZZ_DIV   = 5_000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start_sw,
  input  logic [4:0] i_key_in,
  output logic [3:0] o_key_out,
  output logic       o_buzzer,
  output logic [3:0] o_led,
  output logic [7:0] o_seg_d,
  output logic [3:0] o_seg_com
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int SCAN_W = $clog2(SCAN_CYC + 1);
  localparam int PRE_W  = $clog2(CLK_HZ + 1);
  localparam int DEB_W  = $clog2(DEB_FRAMES + 1);
  localparam int DONE_W = $clog2(DONE_SEC + 1);
  localparam int BUZZ_W = $clog2(BUZZ_DIV + 1);

  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_CYC - 1);
  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(CLK_HZ - 1);
  localparam logic [DEB_W-1:0]  DEB_MAX   = DEB_W'(DEB_FRAMES);
  localparam logic [DONE_W-1:0] DONE_LAST = DONE_W'(DONE_SEC - 1);
  localparam logic [BUZZ_W-1:0] BUZZ_LAST = BUZZ_W'(BUZZ_DIV - 1);

  function automatic logic [7:0] inc_min(input logic [7:0] m);
    if (m == 8'h99)          return m;
    else if (m[3:0] == 4'd9) return {m[7:4] + 4'd1, 4'd0};
    else                     return {m[7:4], m[3:0] + 4'd1};
  endfunction

  function automatic logic [15:0] edit_time(input logic [15:0] t, input logic [4:0] k);
    logic [15:0] r;
    r = t;
    if (k >= 5'd1 && k <= 5'd9) r = {t[11:0], k[3:0]};
    else if (k == 5'd10)        r = {t[11:0], 4'd0};
    else if (k == 5'd12)        r[15:8] = inc_min(t[15:8]);
    else if (k == 5'd13) begin
      if (t[7:4] >= 4'd5) r = {inc_min(t[15:8]), 4'd0, t[3:0]};
      else                r[7:4] = t[7:4] + 4'd1;
    end
    else if (k == 5'd14)        r = 16'h0000;
    return r;
  endfunction

  function automatic logic [15:0] dec_time(input logic [15:0] t);
    if (t[3:0] != 4'd0)      return {t[15:4], t[3:0] - 4'd1};
    else if (t[7:4] != 4'd0) return {t[15:8], t[7:4] - 4'd1, 4'd9};
    else if (t[11:8] != 4'd0) return {t[15:12], t[11:8] - 4'd1, 8'h59};
    else                     return {t[15:12] - 4'd1, 4'd9, 8'h59};
  endfunction

  function automatic logic [7:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 8'h3F;
      4'd1: return 8'h06;
      4'd2: return 8'h5B;
      4'd3: return 8'h4F;
      4'd4: return 8'h66;
      4'd5: return 8'h6D;
      4'd6: return 8'h7D;
      4'd7: return 8'h07;
      4'd8: return 8'h7F;
      4'd9: return 8'h6F;
      default: return 8'h00;
    endcase
  endfunction

  logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [3:0]        col_q, col_d;
  logic [1:0]        dig_q, dig_d;
  logic [4:0]        row_s1_q, row_s2_q;
  logic              sw_s1_q, sw_s2_q, sw_prev_q;
  logic [4:0]        frm_code_q, frm_code_d;
  logic [4:0]        last_code_q, last_code_d;
  logic [DEB_W-1:0]  stab_q, stab_d;
  logic              armed_q, armed_d;
  logic [1:0]        state_q, state_d;
  logic [15:0]       tm_q, tm_d;
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [DONE_W-1:0] done_sec_q, done_sec_d;
  logic [BUZZ_W-1:0] buzz_cnt_q, buzz_cnt_d;
  logic              buzz_q, buzz_d;
  logic [3:0]        led_q, led_d;
  logic [7:0]        seg_d_q, seg_d_d;
  logic [3:0]        seg_com_q, seg_com_d;

  logic [1:0]  col_idx;
  logic [4:0]  col_code, fcode;
  logic        slot_end, frame_end, key_acc, sw_rise, tick, click_on;
  logic [15:0] tm_dec;
  logic [3:0]  dig_val;

  always_comb begin
    case (col_q)
      4'b0010: col_idx = 2'd1;
      4'b0100: col_idx = 2'd2;
      4'b1000: col_idx = 2'd3;
      default: col_idx = 2'd0;
    endcase
    // Scan from the top row down so the lowest active row is the one kept.
    col_code = 5'd0;
    for (int r = 4; r >= 0; r--)
      if (row_s2_q[r]) col_code = 5'(4 * r) + {3'b000, col_idx} + 5'd1;
  end

  `ifdef KEY_CLICK_EN
  localparam int CLICK_LEN = CLK_HZ / 20;
  localparam int CLICK_W   = $clog2(CLICK_LEN + 1);
  logic [CLICK_W-1:0] click_q, click_d;

  always_comb begin
    click_d = click_q;
    if (key_acc)                  click_d = CLICK_W'(CLICK_LEN);
    else if (click_q != '0)       click_d = click_q - CLICK_W'(1);
  end

  assign click_on = (click_q != '0);

  always_ff @(posedge i_clk) begin
    if (i_rst) click_q <= '0;
    else       click_q <= click_d;
  end
  `else
  assign click_on = 1'b0;
  `endif

  always_comb begin
    slot_end    = (scan_cnt_q == SCAN_LAST);
    scan_cnt_d  = slot_end ? '0 : scan_cnt_q + SCAN_W'(1);
    col_d       = slot_end ? {col_q[2:0], col_q[3]} : col_q;
    dig_d       = slot_end ? dig_q - 2'd1 : dig_q;

    // A frame is one pass over all four columns; the first key seen in it represents it.
    frame_end   = 1'b0;
    fcode       = 5'd0;
    frm_code_d  = frm_code_q;
    if (slot_end) begin
      if (col_q[3]) begin
        frame_end  = 1'b1;
        fcode      = (frm_code_q != 5'd0) ? frm_code_q : col_code;
        frm_code_d = 5'd0;
      end else if (frm_code_q == 5'd0) begin
        frm_code_d = col_code;
      end
    end

    last_code_d = last_code_q;
    stab_d      = stab_q;
    armed_d     = armed_q;
    key_acc     = 1'b0;
    if (frame_end) begin
      if (fcode == last_code_q) begin
        if (stab_q != DEB_MAX) stab_d = stab_q + DEB_W'(1);
      end else begin
        last_code_d = fcode;
        stab_d      = DEB_W'(1);
      end
      if (stab_d == DEB_MAX) begin
        if (fcode == 5'd0) armed_d = 1'b1;
        else if (armed_q) begin
          key_acc = 1'b1;
          armed_d = 1'b0;
        end
      end
    end
  end

  always_comb begin
    sw_rise    = sw_s2_q & ~sw_prev_q;
    tick       = (pre_q == PRE_LAST);
    tm_dec     = dec_time(tm_q);
    state_d    = state_q;
    tm_d       = tm_q;
    pre_d      = pre_q;
    done_sec_d = '0;
    case (state_q)
      S_IDLE: begin
        pre_d = '0;
        if (key_acc)                          tm_d = edit_time(tm_q, fcode);
        else if (sw_rise && tm_q != 16'h0000) state_d = S_RUN;
      end
      S_PAUSE: begin
        if (key_acc) begin
          tm_d = edit_time(tm_q, fcode);
          if (fcode == 5'd14) state_d = S_IDLE;
        end else if (sw_s2_q) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // A pause edit can leave 00:00; finish instead of wrapping to 99:59.
        if (!sw_s2_q)               state_d = S_PAUSE;
        else if (tm_q == 16'h0000) begin
          state_d = S_DONE;
          pre_d   = '0;
        end else if (tick) begin
          pre_d = '0;
          tm_d  = tm_dec;
          if (tm_dec == 16'h0000) state_d = S_DONE;
        end else begin
          pre_d = pre_q + PRE_W'(1);
        end
      end
      default: begin
        done_sec_d = done_sec_q;
        if (key_acc || !sw_s2_q) state_d = S_IDLE;
        else if (tick) begin
          pre_d      = '0;
          done_sec_d = done_sec_q + DONE_W'(1);
          if (done_sec_q == DONE_LAST) state_d = S_IDLE;
        end else begin
          pre_d = pre_q + PRE_W'(1);
        end
      end
    endcase
  end

  always_comb begin
    buzz_cnt_d = '0;
    buzz_d     = 1'b0;
    if (state_q == S_DONE || click_on) begin
      buzz_d = buzz_q;
      if (buzz_cnt_q == BUZZ_LAST) buzz_d = ~buzz_q;
      else                         buzz_cnt_d = buzz_cnt_q + BUZZ_W'(1);
    end

    case (state_d)
      S_RUN:   led_d = 4'b0001;
      S_PAUSE: led_d = 4'b0010;
      S_DONE:  led_d = 4'b0100;
      default: led_d = 4'b1000;
    endcase

    case (dig_q)
      2'd3:    dig_val = tm_q[15:12];
      2'd2:    dig_val = tm_q[11:8];
      2'd1:    dig_val = tm_q[7:4];
      default: dig_val = tm_q[3:0];
    endcase
    seg_d_d   = seg_of(dig_val) | ((dig_q == 2'd2) ? 8'h80 : 8'h00);
    seg_com_d = ~(4'b0001 << dig_q);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      scan_cnt_q  <= '0;
      col_q       <= 4'b0001;
      dig_q       <= 2'd3;
      row_s1_q    <= '0;
      row_s2_q    <= '0;
      sw_s1_q     <= 1'b0;
      sw_s2_q     <= 1'b0;
      sw_prev_q   <= 1'b0;
      frm_code_q  <= '0;
      last_code_q <= '0;
      stab_q      <= '0;
      armed_q     <= 1'b1;
      state_q     <= S_IDLE;
      tm_q        <= '0;
      pre_q       <= '0;
      done_sec_q  <= '0;
      buzz_cnt_q  <= '0;
      buzz_q      <= 1'b0;
      led_q       <= 4'b1000;
      seg_d_q     <= 8'h00;
      seg_com_q   <= 4'b1111;
    end else begin
      scan_cnt_q  <= scan_cnt_d;
      col_q       <= col_d;
      dig_q       <= dig_d;
      row_s1_q    <= i_key_in;
      row_s2_q    <= row_s1_q;
      sw_s1_q     <= i_start_sw;
      sw_s2_q     <= sw_s1_q;
      sw_prev_q   <= sw_s2_q;
      frm_code_q  <= frm_code_d;
      last_code_q <= last_code_d;
      stab_q      <= stab_d;
      armed_q     <= armed_d;
      state_q     <= state_d;
      tm_q        <= tm_d;
      pre_q       <= pre_d;
      done_sec_q  <= done_sec_d;
      buzz_cnt_q  <= buzz_cnt_d;
      buzz_q      <= buzz_d;
      led_q       <= led_d;
      seg_d_q     <= seg_d_d;
      seg_com_q   <= seg_com_d;
    end
  end

  assign o_key_out = col_q;
  assign o_buzzer  = buzz_q;
  assign o_led     = led_q;
  assign o_seg_d   = seg_d_q;
  assign o_seg_com = seg_com_q;

endmodule

// File: tb/tb_timer_top_core.sv
// tb/tb_timer_top_core.sv - directed bench for timer_top_core with a behavioural key matrix.
module tb_timer_top_core;

  localparam int CLK_HZ     = 2000;
  localparam int SCAN_CYC   = 4;
  localparam int DEB_FRAMES = 5;
  localparam int DONE_SEC   = 3;
  localparam int BUZZ_DIV   = 5;
  localparam int FRAME      = 4 * SCAN_CYC;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sw  = 1'b0;
  logic [4:0] key_in;
  logic [3:0] key_out;
  logic       buzzer;
  logic [3:0] led;
  logic [7:0] seg_d;
  logic [3:0] seg_com;

  int key_a = 0;
  int key_b = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int cyc_n = 0;

  timer_top_core #(
    .CLK_HZ(CLK_HZ), .SCAN_CYC(SCAN_CYC), .DEB_FRAMES(DEB_FRAMES),
    .DONE_SEC(DONE_SEC), .BUZZ_DIV(BUZZ_DIV)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_start_sw(sw), .i_key_in(key_in),
    .o_key_out(key_out), .o_buzzer(buzzer), .o_led(led),
    .o_seg_d(seg_d), .o_seg_com(seg_com)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Key k sits at row (k-1)/4, column (k-1)%4.
  always_comb begin
    key_in = '0;
    for (int k = 1; k <= 20; k++)
      if ((key_a == k || key_b == k) && key_out[(k-1)%4]) key_in[(k-1)/4] = 1'b1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int k, input int frames);
    key_a = k;
    cyc(frames * FRAME);
    key_a = 0;
    cyc(20 * FRAME);
  endtask

  function automatic logic [3:0] seg2dig(input logic [6:0] s);
    case (s)
      7'h3F: return 4'd0;
      7'h06: return 4'd1;
      7'h5B: return 4'd2;
      7'h4F: return 4'd3;
      7'h66: return 4'd4;
      7'h6D: return 4'd5;
      7'h7D: return 4'd6;
      7'h07: return 4'd7;
      7'h7F: return 4'd8;
      7'h6F: return 4'd9;
      default: return 4'hF;
    endcase
  endfunction

  task automatic read_time(input string tag, input logic [15:0] exp);
    logic [15:0] t;
    logic [3:0]  dp;
    logic [3:0]  want;
    int w;
    t  = '0;
    dp = '0;
    for (int k = 3; k >= 0; k--) begin
      want = ~(4'b0001 << k);
      w = 0;
      while (seg_com !== want && w < 8 * SCAN_CYC) begin
        cyc(1);
        w++;
      end
      if (w >= 8 * SCAN_CYC) check_eq({tag, "_com"}, {28'b0, seg_com}, {28'b0, want});
      t[k*4 +: 4] = seg2dig(seg_d[6:0]);
      dp[k]       = seg_d[7];
    end
    check_eq(tag, {16'b0, t}, {16'b0, exp});
    check_eq({tag, "_dp"}, {28'b0, dp}, 32'h4);
  endtask

  initial begin
    logic b0;
    int   w;
    int   t_set;

    cyc(3);
    check_eq("rst_led", {28'b0, led}, 32'h8);
    check_eq("rst_keyout", {28'b0, key_out}, 32'h1);
    check_eq("rst_buzz", {31'b0, buzzer}, 32'h0);
    check_eq("rst_com", {28'b0, seg_com}, 32'hF);
    check_eq("rst_seg", {24'b0, seg_d}, 32'h0);
    rst = 1'b0;
    cyc(2 * FRAME);

    press(12, 20); press(12, 20);
    read_time("min_inc", 16'h0200);
    press(13, 20); press(13, 20);
    read_time("sec10_inc", 16'h0220);
    press(14, 20);
    read_time("clear", 16'h0000);
    press(7, 20); press(8, 20); press(9, 20);
    read_time("shift_in", 16'h0789);
    check_eq("led_idle", {28'b0, led}, 32'h8);

    sw = 1'b1;
    cyc(10);
    check_eq("led_run", {28'b0, led}, 32'h1);
    cyc(CLK_HZ - 60);
    read_time("pre_tick", 16'h0789);
    cyc(40);
    read_time("first_tick", 16'h0788);
    sw = 1'b0;
    cyc(10);
    check_eq("led_pause", {28'b0, led}, 32'h2);
    cyc(CLK_HZ + 100);
    read_time("frozen", 16'h0788);
    press(14, 20);
    read_time("pause_clear", 16'h0000);
    check_eq("led_clr_idle", {28'b0, led}, 32'h8);

    sw = 1'b1;
    cyc(10);
    check_eq("zero_start", {28'b0, led}, 32'h8);
    sw = 1'b0;
    cyc(10);

    press(9, 20); press(9, 20); press(10, 20); press(10, 20);
    read_time("load_9900", 16'h9900);
    press(12, 20);
    read_time("min_sat", 16'h9900);
    press(14, 20); press(5, 20); press(10, 20);
    read_time("load_0050", 16'h0050);
    press(13, 20);
    read_time("sec10_carry", 16'h0100);

    press(14, 20); press(1, 20);
    read_time("load_0001", 16'h0001);
    sw = 1'b1;
    t_set = cyc_n;
    cyc(CLK_HZ + 20);
    check_eq("led_done", {28'b0, led}, 32'h4);
    read_time("done_time", 16'h0000);
    b0 = buzzer;
    w = 0;
    while (buzzer === b0 && w < 4 * BUZZ_DIV) begin cyc(1); w++; end
    check_eq("buzz_edge", {31'b0, buzzer !== b0}, 32'h1);
    b0 = buzzer;
    w = 0;
    while (buzzer === b0 && w < 4 * BUZZ_DIV) begin cyc(1); w++; end
    check_eq("buzz_half", w, BUZZ_DIV);
    while (cyc_n < t_set + 3 + CLK_HZ + DONE_SEC * CLK_HZ - 20) cyc(1);
    check_eq("done_hold", {28'b0, led}, 32'h4);
    cyc(40);
    check_eq("done_exit", {28'b0, led}, 32'h8);
    check_eq("buzz_off", {31'b0, buzzer}, 32'h0);
    sw = 1'b0;
    cyc(10);

    press(5, 100);
    read_time("held_once", 16'h0005);
    key_a = 3;
    cyc(2 * FRAME);
    key_a = 0;
    cyc(20 * FRAME);
    read_time("glitch", 16'h0005);
    key_a = 1;
    key_b = 5;
    cyc(20 * FRAME);
    key_a = 0;
    key_b = 0;
    cyc(20 * FRAME);
    read_time("two_row", 16'h0051);

    sw = 1'b1;
    cyc(20);
    check_eq("led_run2", {28'b0, led}, 32'h1);
    rst = 1'b1;
    cyc(1);
    check_eq("rst_run_led", {28'b0, led}, 32'h8);
    check_eq("rst_run_buzz", {31'b0, buzzer}, 32'h0);
    sw  = 1'b0;
    rst = 1'b0;
    cyc(5);
    read_time("rst_run_time", 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
